// File: rtl/gmm_prob_argmax_tree_pkg.sv
// gmm_prob_argmax_tree_pkg
// Shared types and helpers for the GMM argmax comparator tree.
//   argmax_cand_t    : one tree candidate {valid, key, idx[, score]}
//   fp32_is_nan      : IEEE-754 single NaN test (exp 0xFF, mantissa != 0)
//   fp32_canon       : maps -0 to +0
//   fp32_order_key   : unsigned key whose ordering matches the float ordering
//   level_width      : number of candidates at a given tree level
// Optional build macro: GMM_ARGMAX_MAX_VALUE_EN (adds the raw winning score).
package gmm_prob_argmax_tree_pkg;

  localparam int unsigned FP32_W     = 32;
  localparam int unsigned CAND_IDX_W = 3;

  typedef struct packed {
    logic                  valid;
    logic [FP32_W-1:0]     key;
    logic [CAND_IDX_W-1:0] idx;
`ifdef GMM_ARGMAX_MAX_VALUE_EN
    logic [FP32_W-1:0]     score;
`endif
  } argmax_cand_t;

  function automatic logic fp32_is_nan(input logic [FP32_W-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [FP32_W-1:0] fp32_canon(input logic [FP32_W-1:0] x);
    return (x == 32'h8000_0000) ? 32'h0000_0000 : x;
  endfunction

  // Negative values invert every bit so larger magnitude sorts lower;
  // positive values flip the sign bit so they sort above all negatives.
  function automatic logic [FP32_W-1:0] fp32_order_key(input logic [FP32_W-1:0] x);
    logic [FP32_W-1:0] c;
    c = fp32_canon(x);
    return c[31] ? ~c : (c ^ 32'h8000_0000);
  endfunction

  function automatic int unsigned level_width(input int unsigned n, input int unsigned lvl);
    return (n + (32'd1 << lvl) - 32'd1) >> lvl;
  endfunction

endpackage

// File: rtl/gmm_prob_argmax_tree_if.sv
// gmm_prob_argmax_tree_if
// Stream bundle for the argmax stage.
//   snk_* : input beat (scores, active count, sideband) with valid/ready
//   src_* : output beat (index, none flag, sideband[, max score]) with valid/ready
//   master: producer/consumer side, slave: the argmax stage
// Optional build macro: GMM_ARGMAX_MAX_VALUE_EN (adds src_max).
interface gmm_prob_argmax_tree_if #(
  parameter int unsigned N_CLUSTERS = 4,
  parameter int unsigned SIDE_W     = 32
);
  localparam int unsigned IDX_W = $clog2(N_CLUSTERS);
  localparam int unsigned CNT_W = $clog2(N_CLUSTERS + 1);

  logic                     snk_valid;
  logic                     snk_ready;
  logic [N_CLUSTERS*32-1:0] snk_score;
  logic [CNT_W-1:0]         snk_count;
  logic [SIDE_W-1:0]        snk_side;
  logic                     src_ready;
  logic                     src_valid;
  logic [IDX_W-1:0]         src_idx;
  logic                     src_none;
  logic [SIDE_W-1:0]        src_side;
`ifdef GMM_ARGMAX_MAX_VALUE_EN
  logic [31:0]              src_max;
`endif

  modport master (
`ifdef GMM_ARGMAX_MAX_VALUE_EN
    input  src_max,
`endif
    output snk_valid, snk_score, snk_count, snk_side, src_ready,
    input  snk_ready, src_valid, src_idx, src_none, src_side
  );

  modport slave (
`ifdef GMM_ARGMAX_MAX_VALUE_EN
    output src_max,
`endif
    input  snk_valid, snk_score, snk_count, snk_side, src_ready,
    output snk_ready, src_valid, src_idx, src_none, src_side
  );

endinterface

// File: rtl/gmm_prob_argmax_tree_node.sv
// gmm_prob_argmax_tree_node
// One registered comparator node of the argmax tree.
//   clk, rst : clock, async active-high reset
//   en_i     : global pipeline advance
//   left_i   : lower-index candidate, right_i : higher-index candidate
//   win_o    : registered winner; all-zero when neither side is valid
// Optional build macro: GMM_ARGMAX_MAX_VALUE_EN (score rides in the candidate).
module gmm_prob_argmax_tree_node
  import gmm_prob_argmax_tree_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  argmax_cand_t left_i,
  input  argmax_cand_t right_i,
  output argmax_cand_t win_o
);

  argmax_cand_t win_d;
  argmax_cand_t win_q;
  logic         right_wins_c;

  // Strictly greater needed for the right side, so ties stay with the lower index.
  always_comb begin
    win_d        = '0;
    right_wins_c = right_i.valid & (!left_i.valid | (right_i.key > left_i.key));
    if (right_wins_c) begin
      win_d = right_i;
    end else if (left_i.valid) begin
      win_d = left_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q <= '0;
    end else if (en_i) begin
      win_q <= win_d;
    end
  end

  assign win_o = win_q;

endmodule

// File: rtl/gmm_prob_argmax_tree.sv
// gmm_prob_argmax_tree
// Registered argmax over N_CLUSTERS FP32 scores with deterministic tie, NaN and
// signed-zero handling. Latency 1 + $clog2(N_CLUSTERS), one beat per cycle.
//   clk, rst : clock, async active-high reset
//   bus      : gmm_prob_argmax_tree_if slave (snk_* in, src_* out)
// Optional build macro: GMM_ARGMAX_MAX_VALUE_EN (drives src_max with the winning score).
module gmm_prob_argmax_tree
  import gmm_prob_argmax_tree_pkg::*;
#(
  parameter int unsigned N_CLUSTERS = 4,
  parameter int unsigned SIDE_W     = 32
) (
  input logic                  clk,
  input logic                  rst,
  gmm_prob_argmax_tree_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N_CLUSTERS);
  localparam int unsigned CNT_W = $clog2(N_CLUSTERS + 1);
  localparam int unsigned LVLS  = $clog2(N_CLUSTERS);
  localparam int unsigned NP    = 32'd1 << LVLS;

  logic             en_c;
  logic [CNT_W-1:0] eff_cnt_c;

  argmax_cand_t lane_d [N_CLUSTERS];
  argmax_cand_t lane_q [N_CLUSTERS];
  argmax_cand_t lvl    [LVLS+1][NP];

  logic [LVLS:0]     vld_q;
  logic [SIDE_W-1:0] side_q [LVLS+1];

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign en_c          = bus.src_ready | !bus.src_valid;
  assign bus.snk_ready = en_c;

  assign eff_cnt_c = (bus.snk_count > CNT_W'(N_CLUSTERS)) ? CNT_W'(N_CLUSTERS) : bus.snk_count;

  // Stage 0 lane candidates; bubbles enter as all-invalid lanes.
  always_comb begin
    for (int k = 0; k < int'(N_CLUSTERS); k++) begin
      lane_d[k]       = '0;
      lane_d[k].valid = bus.snk_valid & (CNT_W'(k) < eff_cnt_c) &
                        !fp32_is_nan(bus.snk_score[k*32 +: 32]);
      lane_d[k].key   = fp32_order_key(bus.snk_score[k*32 +: 32]);
      lane_d[k].idx   = CAND_IDX_W'(k);
`ifdef GMM_ARGMAX_MAX_VALUE_EN
      lane_d[k].score = fp32_canon(bus.snk_score[k*32 +: 32]);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(N_CLUSTERS); k++) begin
        lane_q[k] <= '0;
      end
    end else if (en_c) begin
      lane_q <= lane_d;
    end
  end

  // Beat valid and sideband shift alongside the tree levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i <= int'(LVLS); i++) begin
        side_q[i] <= '0;
      end
    end else if (en_c) begin
      vld_q     <= {vld_q[LVLS-1:0], bus.snk_valid};
      side_q[0] <= bus.snk_side;
      for (int i = 1; i <= int'(LVLS); i++) begin
        side_q[i] <= side_q[i-1];
      end
    end
  end

  for (genvar j = 0; j < int'(NP); j++) begin : g_l0
    if (j < int'(N_CLUSTERS)) begin : g_lane
      assign lvl[0][j] = lane_q[j];
    end else begin : g_pad
      assign lvl[0][j] = '0;
    end
  end

  // An unpaired candidate meets an invalid right input and so passes through registered.
  for (genvar l = 1; l <= int'(LVLS); l++) begin : g_lvl
    for (genvar j = 0; j < int'(NP); j++) begin : g_node
      if (j < int'(level_width(N_CLUSTERS, l))) begin : g_live
        argmax_cand_t right_c;
        argmax_cand_t node_win;
        if (2*j + 1 < int'(level_width(N_CLUSTERS, l - 1))) begin : g_pair
          assign right_c = lvl[l-1][2*j+1];
        end else begin : g_odd
          assign right_c = '0;
        end
        gmm_prob_argmax_tree_node u_node (
          .clk     (clk),
          .rst     (rst),
          .en_i    (en_c),
          .left_i  (lvl[l-1][2*j]),
          .right_i (right_c),
          .win_o   (node_win)
        );
        assign lvl[l][j] = node_win;
      end else begin : g_idle
        assign lvl[l][j] = '0;
      end
    end
  end

  // Root is all-zero when nothing valid reached it, so idx and max read 0 there.
  assign bus.src_valid = vld_q[LVLS];
  assign bus.src_idx   = lvl[LVLS][0].idx[IDX_W-1:0];
  assign bus.src_none  = vld_q[LVLS] & !lvl[LVLS][0].valid;
  assign bus.src_side  = side_q[LVLS];
`ifdef GMM_ARGMAX_MAX_VALUE_EN
  assign bus.src_max   = lvl[LVLS][0].score;
`endif

endmodule

// File: doc/gmm_prob_argmax_tree.md
# gmm_prob_argmax_tree

Parametrised N-cluster argmax stage for the GMM foreground detector. It accepts one FP32 likelihood score per cluster together with the pixel's active-cluster count. It returns the index of the largest score among the active clusters and carries an opaque sideband word alongside. It replaces the fixed three-comparator selection at the tail of the subtract/probability pipeline with a registered comparator tree that scales to any cluster count and has deterministic tie, NaN and signed-zero handling.

## Interface
- N_CLUSTERS, 4, number of score lanes; legal range 2..8
- IDX_W, $clog2(N_CLUSTERS), index width (derived, not overridable)
- CNT_W, $clog2(N_CLUSTERS+1), active-count width (derived)
- SIDE_W, 32, sideband width passed through unchanged
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- snk_valid  in  1  input beat valid
- snk_ready  out  1  input beat accepted when snk_valid & snk_ready
- snk_score  in  N_CLUSTERS×32  IEEE-754 single scores, lane k = cluster k
- snk_count  in  CNT_W  active clusters; lanes ≥ count are ignored
- snk_side  in  SIDE_W  sideband (mega_data_t payload)
- src_ready  in  1  downstream ready
- src_valid  out  1  output beat valid
- src_idx  out  IDX_W  argmax index
- src_none  out  1  set when the effective count was 0
- src_side  out  SIDE_W  sideband of the same beat
- src_max  out  32  winning score (only with GMM_ARGMAX_MAX_VALUE_EN)

## Operation
- Stage 0 (input register): per lane, latch the score, a lane-valid bit and the lane index.
  - lane_valid = (k < min(count, N_CLUSTERS)) & !isNaN(score).
  - NaN means exponent 0xFF and mantissa ≠ 0. ±Inf are ordinary values.
  - count > N_CLUSTERS saturates to N_CLUSTERS.
- Ordering key: a 32-bit unsigned value.
  - First canonicalise −0 (0x80000000) to +0.
  - key = sign ? ~x : x ^ 32'h8000_0000.
- Tree: L = $clog2(N_CLUSTERS) registered levels. Each node merges a left (lower index) and a right candidate.
  - Right wins only if right.valid & (!left.valid | right.key > left.key).
  - Otherwise left wins. Ties therefore go to the lower index.
  - Node output valid = left.valid | right.valid.
  - An odd lane with no partner passes through its level registered, unchanged.
- Output (root of the tree):
  - src_idx = winner index; src_none = !root.valid.
  - When root.valid = 0 (count 0 or all NaN): src_idx = 0 and src_max = 0.
- Sideband and count travel in a shift register alongside the tree.

## Timing
- Latency: 1 + L cycles from acceptance to src_valid, with no stalls.
  - N=2 → 2 cycles, N=3..4 → 3, N=5..8 → 4.
- Throughput: one beat per cycle.
- Flow control uses a global enable: en = src_ready | !src_valid.
  - snk_ready = en.
  - All stage registers, including the valid chain, advance only when en = 1.
  - There is no bubble collapsing.
- src_* outputs hold stable while src_valid & !src_ready.
- snk_valid with en = 0 has no effect.
- Reset: every stage valid = 0, src_valid = 0, src_idx = 0, src_none = 0, src_side = 0, src_max = 0, snk_ready = 1. Reset takes effect immediately and asynchronously.
- Reset mid-operation: all in-flight beats are discarded and nothing is emitted afterwards for them.

## Configuration
- GMM_ARGMAX_MAX_VALUE_EN defined:
  - Each node also carries the raw 32-bit winning score (the canonicalised +0 for zeros).
  - src_max is a real port.
- Not defined:
  - The src_max port is absent and no score data is stored beyond what the key requires.
  - Keys are kept, since they are the sign-transformed score.
  - Index and valid behaviour are identical in both builds.

## Structure
- In gmm_structures:
  - function fp32_order_key (includes −0 canonicalisation).
  - function fp32_is_nan.
  - typedef argmax_cand_t {valid, key, idx[2:0]}.
- Sub-module gmm_argmax_node:
  - one registered comparator node with en input and the tie rule above.
  - Instantiated in a generate loop per level.

## Test plan
1. N=4, scores {1.0, 3.0, 2.0, 0.5}, count=4 → src_idx=1, src_none=0, latency 3 cycles, side echoed.
2. N=4, scores {2.0, 2.0, −0.0, +0.0}, count=4 → idx 0. Scores {−0.0, +0.0, −1.0, −1.0} → idx 0 (zeros equal, lower index wins).
3. N=4, scores {1.0, 5.0, 9.0, 7.0}, count=2 → idx 1. Same scores with count=0 → src_none=1, idx 0. Same scores with count=7 (saturates to 4) → idx 2.
4. N=4, scores {0x7FC00000 (NaN), −Inf, 0x7F800000 (+Inf), 1.0}, count=4 → idx 2. All four NaN → src_none=1.
5. N=5 and N=8 builds, random 10k beats against a reference model → all idx match, including the odd-lane passthrough.
6. Back-to-back stream with src_ready toggled 1/0/0/1 and rst asserted for one cycle mid-stream:
   - no beat is lost, duplicated or reordered before the reset;
   - outputs are stable during stalls;
   - src_valid = 0 immediately on rst, and only post-reset beats appear afterwards.
